// File: rtl/pla_eval_scheduler_if.sv
`default_nettype none
// ============================================================
// pla_eval_scheduler_if
// Request/response handshake bundle between clients and scheduler.
// Rev 1.0
// ============================================================
interface pla_eval_scheduler_if #(
  parameter int NREQ  = 4,
  parameter int IN_W  = 25,
  parameter int OUT_W = 8
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*IN_W-1:0] req_vec;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      rsp_valid;
  logic [NREQ-1:0]      rsp_ready;
  logic [OUT_W-1:0]     rsp_z;

  modport master (
    output req_valid, req_vec, rsp_ready,
    input  req_ready, rsp_valid, rsp_z
  );

  modport slave (
    input  req_valid, req_vec, rsp_ready,
    output req_ready, rsp_valid, rsp_z
  );
endinterface
`default_nettype wire

// File: rtl/pla_eval_scheduler.sv
`default_nettype none
// ============================================================
// pla_eval_scheduler
// Round-robin front end sharing one PLA among NREQ requesters.
// Optional one-entry result cache: define PLA_SCHED_CACHE_EN.
// Rev 1.0
// ============================================================
module pla_eval_scheduler #(
  parameter int NREQ    = 4,
  parameter int IN_W    = 25,
  parameter int OUT_W   = 8,
  parameter int PLA_LAT = 0
) (
  input  logic                clk,
  input  logic                rst,
  pla_eval_scheduler_if.slave bus,
  output logic [IN_W-1:0]     pla_x,
  input  logic [OUT_W-1:0]    pla_z,
  output logic                busy
);
  localparam int GW = $clog2(NREQ);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EVAL = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       state_r;
  logic [GW-1:0]    ptr_r;
  logic [GW-1:0]    gnt_r;
  logic [3:0]       cnt_r;
  logic [IN_W-1:0]  vec_r;
  logic [OUT_W-1:0] rsp_z_r;

  logic [IN_W-1:0]  req_slice [NREQ];
  logic             any_w;
  logic [GW-1:0]    win_w;
  logic [GW-1:0]    cand;
  logic [IN_W-1:0]  win_vec_w;
  logic             accept_w;
  logic             hit_w;
  logic [OUT_W-1:0] hit_z_w;
  logic             capture_w;

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign req_slice[i] = bus.req_vec[i*IN_W +: IN_W];
  end

  // First valid requester at or after ptr_r, wrapping modulo NREQ.
  always_comb begin
    any_w = 1'b0;
    win_w = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = GW'((int'(ptr_r) + k) % NREQ);
      if (!any_w && bus.req_valid[cand]) begin
        any_w = 1'b1;
        win_w = cand;
      end
    end
  end

  assign win_vec_w = req_slice[win_w];
  assign accept_w  = (state_r == S_IDLE) && any_w && !rst;
  assign capture_w = (state_r == S_EVAL) && (cnt_r == 4'd0);

`ifdef PLA_SCHED_CACHE_EN
  logic             c_valid_r;
  logic [IN_W-1:0]  c_vec_r;
  logic [OUT_W-1:0] c_z_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_valid_r <= 1'b0;
      c_vec_r   <= '0;
      c_z_r     <= '0;
    end else if (capture_w) begin
      c_valid_r <= 1'b1;
      c_vec_r   <= vec_r;
      c_z_r     <= pla_z;
    end
  end

  assign hit_w   = c_valid_r && (c_vec_r == win_vec_w);
  assign hit_z_w = c_z_r;
`else
  assign hit_w   = 1'b0;
  assign hit_z_w = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
      ptr_r   <= '0;
      gnt_r   <= '0;
      cnt_r   <= 4'd0;
      vec_r   <= '0;
      rsp_z_r <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (any_w) begin
            gnt_r <= win_w;
            ptr_r <= (win_w == GW'(NREQ - 1)) ? '0 : win_w + GW'(1);
            if (hit_w) begin
              // Cached result: skip the PLA and leave pla_x untouched.
              rsp_z_r <= hit_z_w;
              state_r <= S_RESP;
            end else begin
              vec_r   <= win_vec_w;
              cnt_r   <= 4'(PLA_LAT);
              state_r <= S_EVAL;
            end
          end
        end
        S_EVAL: begin
          if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end else begin
            rsp_z_r <= pla_z;
            state_r <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready[gnt_r]) begin
            state_r <= S_IDLE;
          end
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = accept_w ? (NREQ'(1) << win_w) : '0;
  assign bus.rsp_valid = (state_r == S_RESP) ? (NREQ'(1) << gnt_r) : '0;
  assign bus.rsp_z     = rsp_z_r;
  assign pla_x         = vec_r;
  assign busy          = (state_r != S_IDLE);

endmodule
`default_nettype wire
